// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, queue depth and fetch-state encoding for the fetch front end
package ifetch_pkg;
  localparam int IF_DATAWIDTH = 16;
  localparam int IF_IMMWIDTH = 16;
  localparam int IF_DEPTH = 4;
  localparam int IF_CNTW = 3;
  typedef enum logic {RUN, DRAIN} state_e;
endpackage

// File: rtl/ifetch_unit_fifo.sv
// fetch_fifo: registered circular queue with clear; head is visible the cycle after its push
module fetch_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4,
  parameter int CNTW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic [W-1:0]    data_i,
  input  logic            pop_i,
  output logic [W-1:0]    data_o,
  output logic [CNTW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_d, wr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CNTW'(DEPTH);
  assign do_pop = pop_i & !empty_o;
  assign do_push = push_i & (!full_o | do_pop);
  assign rd_d = do_pop ? inc(rd_q) : rd_q;
  assign wr_d = do_push ? inc(wr_q) : wr_q;
  assign cnt_d = cnt_q + CNTW'(do_push) - CNTW'(do_pop);
  assign data_o = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
  // pointers and occupancy; clear and reset both empty the queue
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // storage write; contents need no reset since empty masks the head
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: credit-limited instruction fetch with in-order response queue and stale-response drop
module ifetch_unit import ifetch_pkg::*; #(
  parameter int DATAWIDTH = IF_DATAWIDTH,
  parameter int DEPTH = IF_DEPTH,
  parameter int CNTW = IF_CNTW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATAWIDTH-1:0] pc_i,
  input  logic                 flush_i,
  output logic                 pc_en_o,
  output logic                 mem_req_o,
  output logic [DATAWIDTH-1:0] mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DATAWIDTH-1:0] mem_rdata_i,
  output logic                 inst_valid_o,
  output logic [DATAWIDTH-1:0] inst_o,
  output logic [DATAWIDTH-1:0] inst_pc_o,
  input  logic                 inst_ready_i
);
  logic [DATAWIDTH-1:0] head_addr;
  logic [2*DATAWIDTH-1:0] head_entry;
  logic [CNTW-1:0] outstanding, inst_cnt, occupancy, drop_q, drop_d;
  logic addr_full, addr_empty, inst_full, inst_empty;
  logic issue, resp, keep, pop;
  state_e state_q;
  // the address queue holds exactly the in-flight requests, so its depth is the outstanding count
  assign occupancy = outstanding + inst_cnt;
  assign mem_req_o = rst_ni & !flush_i & !addr_full & !inst_full & (occupancy < CNTW'(DEPTH));
  assign issue = mem_req_o & mem_gnt_i;
  assign pc_en_o = rst_ni & (flush_i | issue);
  assign mem_addr_o = pc_i;
  assign resp = mem_rvalid_i & !addr_empty;
  assign keep = resp & (state_q == RUN) & !flush_i;
  assign pop = inst_valid_o & inst_ready_i;
  assign inst_valid_o = !inst_empty;
  assign {inst_o, inst_pc_o} = head_entry;
  assign drop_d = flush_i ? outstanding - CNTW'(resp) : drop_q - CNTW'(resp & (state_q == DRAIN));
  fetch_fifo #(.W(DATAWIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) u_addr_q (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(1'b0), .push_i(issue), .data_i(pc_i),
    .pop_i(resp), .data_o(head_addr), .count_o(outstanding), .full_o(addr_full), .empty_o(addr_empty)
  );
  fetch_fifo #(.W(2*DATAWIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) u_inst_q (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(flush_i), .push_i(keep), .data_i({mem_rdata_i, head_addr}),
    .pop_i(pop), .data_o(head_entry), .count_o(inst_cnt), .full_o(inst_full), .empty_o(inst_empty)
  );
  // stale-response counter and RUN/DRAIN state, which is DRAIN exactly while drops remain
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drop_q <= '0;
      state_q <= RUN;
    end else begin
      drop_q <= drop_d;
      state_q <= (drop_d != '0) ? DRAIN : RUN;
    end
  end
endmodule
